// File: rtl/div_unit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_seq_if
// Description : Request/result bundle for the multicycle divider.
//               master : issues start + operands, observes results/status
//               slave  : the divider itself
//   start      request, accepted only while busy=0
//   sign_mode  1 = two's complement operands, 0 = unsigned
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   q, r       quotient / remainder, held until the next accepted start
//   busy       division in progress
//   done       one-cycle pulse when q/r/div_zero are fresh
//   div_zero   last division had a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, sign_mode, dividend, divisor,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output q, r, busy, done, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/div_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_seq
// Description : Parametrised multicycle restoring divider, signed/unsigned.
//               One shift-subtract step per cycle on operand magnitudes,
//               followed by a sign-correction cycle. Latency WIDTH+1 cycles.
// Ports       : clock    - rising-edge clock
//               reset    - synchronous, active-low reset (0 = reset)
//               bus      - div_unit_seq_if.slave (start/operands in,
//                          q/r/busy/done/div_zero out)
// Options     : DIV_EARLY_EXIT_EN - when defined, a zero divisor or
//               |dividend| < |divisor| skips the iteration and completes in
//               one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  div_unit_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Control strobes from the FSM
  logic load;
  logic step;
  logic finish;

  // Working registers
  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] quo;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs;        // |divisor|
  logic [WIDTH-1:0] dvd_orig;   // untouched dividend, returned on divide-by-zero
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [CNT_W-1:0] cnt;

  // Result registers
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             done_out;
  logic             dz_out;

  // Operand magnitudes; |MIN| stays MIN and is treated as unsigned.
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             early;

  always_comb begin
    dvd_abs = (bus.sign_mode && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    dvs_abs = (bus.sign_mode && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  end

`ifdef DIV_EARLY_EXIT_EN
  assign early = (bus.divisor == '0) || (dvd_abs < dvs_abs);
`else
  assign early = 1'b0;
`endif

  // One restoring step: the remainder is widened by a bit so a divisor with
  // its MSB set cannot overflow the shifted value; the top bit of the
  // difference is the borrow.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           sub_ok;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    sub_ok = ~diff[WIDTH];
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = early ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dvd_orig <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      q_out    <= '0;
      r_out    <= '0;
      done_out <= 1'b0;
      dz_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (load) begin
        dvs      <= dvs_abs;
        dvd_orig <= bus.dividend;
        q_neg    <= bus.sign_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_neg    <= bus.sign_mode & bus.dividend[WIDTH-1];
        dz       <= (bus.divisor == '0);
        if (early) begin
          // Quotient is trivially zero; the magnitude is the remainder and
          // the sign fix-up restores the original dividend.
          rem <= dvd_abs;
          quo <= '0;
          cnt <= '0;
        end else begin
          rem <= '0;
          quo <= dvd_abs;
          cnt <= CNT_W'(WIDTH);
        end
      end

      if (step) begin
        rem <= sub_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], sub_ok};
        cnt <= cnt - CNT_W'(1);
      end

      if (finish) begin
        if (dz) begin
          q_out <= '1;
          r_out <= dvd_orig;
        end else begin
          q_out <= q_neg ? -quo : quo;
          r_out <= r_neg ? -rem : rem;
        end
        dz_out   <= dz;
        done_out <= 1'b1;
      end
    end
  end

  assign bus.q        = q_out;
  assign bus.r        = r_out;
  assign bus.div_zero = dz_out;
  assign bus.done     = done_out;
  assign bus.busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit_seq
// Description : Self-checking bench for div_unit_seq (WIDTH=32). A reference
//               model computes results with plain integer arithmetic and a
//               latency countdown; every cycle the DUT outputs are compared
//               against it, and directed operations carry hand-computed
//               literal results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit_seq;

  localparam int WIDTH = 32;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  div_unit_seq_if #(.WIDTH(WIDTH)) bus ();

  div_unit_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Arithmetic reference for one division.
  function automatic void model(input logic sm, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edz, output bit eearly);
    longint sa, sb, mq, mr, mag_a, mag_b;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    mag_a = sm ? ((sa < 0) ? -sa : sa) : longint'(a);
    mag_b = sm ? ((sb < 0) ? -sb : sb) : longint'(b);
    eearly = (b == 32'd0) || (mag_a < mag_b);
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
    end else if (sm) begin
      mq = sa / sb;
      mr = sa % sb;
      eq = mq[31:0]; er = mr[31:0]; edz = 1'b0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endfunction

  // Cycle-level expectation of the outputs.
  logic        m_busy, m_done, m_dz, p_dz;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          remaining;

  always @(posedge clock) begin : model_p
    logic [31:0] eq, er;
    logic        edz;
    bit          eearly;
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
      remaining <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (remaining == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
        end
        remaining <= remaining - 1;
      end else if (bus.start) begin
        model(bus.sign_mode, bus.dividend, bus.divisor, eq, er, edz, eearly);
        p_q <= eq; p_r <= er; p_dz <= edz;
        m_busy <= 1'b1;
        remaining <= (EARLY && eearly) ? 1 : WIDTH + 1;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("q", bus.q, m_q);
      chk("r", bus.r, m_r);
      chk("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
    end
  end

  // Issue one operation at the current negedge, wait for done, and check the
  // literal result and latency. Returns in the done cycle so a following
  // call starts back-to-back.
  task automatic do_op(input string name, input logic sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input bit early_case);
    int n;
    int exp_lat;
    logic [31:0] mq, mr;
    logic mdz;
    bit me;
    model(sm, a, b, mq, mr, mdz, me);
    chk({name, " model q"}, mq, eq);
    chk({name, " model r"}, mr, er);
    exp_lat = (EARLY && early_case) ? 1 : WIDTH + 1;
    bus.start = 1'b1; bus.sign_mode = sm; bus.dividend = a; bus.divisor = b;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) bus.start = 1'b0;
    end while (!bus.done && n < 60);
    chk({name, " latency"}, 32'(n - 1), 32'(exp_lat));
    chk({name, " q"}, bus.q, eq);
    chk({name, " r"}, bus.r, er);
    chk({name, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.sign_mode = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clock);
    check_en = 1'b1;
    chk("reset q", bus.q, 32'd0);
    chk("reset r", bus.r, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    do_op("u100/7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0);
    do_op("s-7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("s7/-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
    do_op("sMIN/-1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b0);
    do_op("uMIN/-1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b1);
    do_op("u5/0",     1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b1);
    do_op("s5/0",     1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b1);
    do_op("s-3/10",   1'b1, 32'hFFFF_FFFD, 32'd10,        32'd0,         32'hFFFF_FFFD, 1'b0, 1'b1);
    // Started in the done cycle of the previous operation.
    do_op("u9/3 b2b", 1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 1'b0);

    // Reset in the middle of an operation; a start while busy is ignored.
    repeat (2) @(negedge clock);
    bus.start = 1'b1; bus.sign_mode = 1'b0; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    bus.start = 1'b1; bus.dividend = 32'h0000_1234; bus.divisor = 32'd5;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset q", bus.q, 32'd0);
    chk("midreset r", bus.r, 32'd0);
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset div_zero", {31'd0, bus.div_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    do_op("uMAX/1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);

    // Results must hold while idle.
    repeat (3) @(negedge clock);
    chk("hold q", bus.q, 32'hFFFF_FFFF);
    chk("hold done", {31'd0, bus.done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit_seq.md
Name: div_unit_seq

Overview:
- Parametrised multicycle integer divider; successor to the fixed 32-bit unsigned divider in the CPU execute stage.
- Adds a signed/unsigned mode, WIDTH parametrisation, an explicit done pulse, a divide-by-zero flag and held results.
- Serves MIPS DIV/DIVU; the pipeline stalls on busy and writes HI/LO on done.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset)
- start  in  1  request; accepted only when busy=0
- sign_mode  in  1  1 = signed (two's complement), 0 = unsigned; sampled with start
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- q  out  WIDTH  quotient; held until next accepted start
- r  out  WIDTH  remainder; held until next accepted start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse when q/r are valid
- div_zero  out  1  divisor was zero; valid with done, held like q/r

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE; q=0, r=0, busy=0, done=0, div_zero=0; counter=0. Reset overrides any in-flight operation, and the result is discarded.
- States:
  - IDLE: waiting for start.
  - CALC: one restoring shift-subtract step per cycle.
  - FIX: sign correction, then result write.
- IDLE to CALC: start=1 at edge N. At that edge:
  - Latch |dividend|, |divisor|, sign_mode, sign of quotient (dividend_msb XOR divisor_msb, signed mode only) and sign of remainder (dividend_msb).
  - busy=1, counter=WIDTH, done=0.
- CALC: at each edge N+1..N+WIDTH, partial remainder {rem,quo} shifts left 1. If rem >= |divisor|, subtract and set quo LSB=1. Counter decrements; at counter=1 the next state is FIX.
- FIX (edge N+WIDTH+1):
  - Negate quo if quotient sign=1; negate rem if remainder sign=1.
  - Write q and r, set done=1 and busy=0, return to IDLE.
- Total latency is WIDTH+1 cycles from start to done (33 for WIDTH=32).
- done is high for exactly one cycle. A start asserted while done=1 is accepted, giving back-to-back operation with no bubble.
- start while busy=1 is ignored, with no effect on the operation or the operands.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend; dividend = q*divisor + r (mod 2^WIDTH).
  - Overflow case MIN/-1 gives q=MIN (wraps), r=0, div_zero=0.
  - Absolute values use WIDTH-bit magnitude, and |MIN| = MIN interpreted unsigned.
- Unsigned semantics: plain restoring division; no fix-up.
- Divide by zero: runs the full latency (unless the optional feature is enabled). Result is q=all-ones and r=dividend (original, unmodified), div_zero=1, in both modes.
- Between operations q, r and div_zero are stable; they change only at the FIX edge or at reset.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: from IDLE on start, go straight to FIX so done arrives at edge N+1 (latency 1) in either of two cases:
  - Divisor is zero: result per the divide-by-zero rules.
  - |dividend| < |divisor| (unsigned compare of magnitudes): q=0, r=dividend.
  - All other cases take WIDTH+1 cycles.
- Undefined: latency is always WIDTH+1, independent of operands.

Test Plan:
- WIDTH=32, unsigned 100/7; start at cycle 0 -> done at cycle 33 with q=14, r=2, div_zero=0; busy high cycles 1..33 edges, low with done.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); signed 7/-2 -> q=-3, r=1.
- Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, div_zero=0; the same operands unsigned -> q=0, r=0x80000000.
- 5/0 in both modes -> q=0xFFFFFFFF, r=5, div_zero=1. Latency is 33, or 1 with DIV_EARLY_EXIT_EN.
- Start 0xFFFFFFFF/1 unsigned, pulse start with other operands at cycle 10, drive reset=0 at cycle 20 -> outputs all 0 and busy=0 at the next edge. Restart 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Back-to-back: assert start with 9/3 in the done cycle of a previous op -> the previous result is visible for one cycle, then the new done 33 cycles later with q=3, r=0.
